// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer_if
// Purpose  : Handshake and control bundle between the sequencer and its
//            surroundings (instruction memory, ALU, pc_block).
// Revision : 1.0 - initial release
// ============================================================================
interface pc_sequencer_if;
  logic        start;
  logic        memReady;
  logic [3:0]  opcode;
  logic        cmpTrue;
  logic        stall;
  logic [3:0]  pcSrc;
  logic        pcWrite;
  logic        irWrite;
  logic        halted;
  logic [15:0] instrCount;

  // master is the sequencer itself; slave is the environment feeding it
  modport master (
    input  start, memReady, opcode, cmpTrue, stall,
    output pcSrc, pcWrite, irWrite, halted, instrCount
  );

  modport slave (
    output start, memReady, opcode, cmpTrue, stall,
    input  pcSrc, pcWrite, irWrite, halted, instrCount
  );
endinterface
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Fetch/decode/execute control FSM producing PC mux select,
//            PC/IR load enables and a completed-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer (
  input  logic           clock,
  input  logic           reset,
  pc_sequencer_if.master bus
);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_FETCH  = 3'd1;
  localparam logic [2:0] c_DECODE = 3'd2;
  localparam logic [2:0] c_EXEC   = 3'd3;
  localparam logic [2:0] c_HALT   = 3'd4;

  localparam logic [3:0] c_OP_HALT = 4'hF;

  logic [2:0]  r_state;
  logic [2:0]  w_next_state;
  logic [3:0]  r_op_reg;
  logic [15:0] r_instr_count;
  logic [3:0]  w_pc_src;
  logic        w_pc_write;
  logic        w_ir_write;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:   if (bus.start) w_next_state = c_FETCH;
      c_FETCH:  if (bus.memReady) w_next_state = c_DECODE;
      c_DECODE: w_next_state = (r_op_reg == c_OP_HALT) ? c_HALT : c_EXEC;
      c_EXEC:   if (!bus.stall) w_next_state = c_FETCH;
      c_HALT:   w_next_state = c_HALT;
      default:  w_next_state = c_IDLE;
    endcase
  end

  assign w_ir_write = (r_state == c_FETCH) && bus.memReady;
  assign w_pc_write = (r_state == c_EXEC) && !bus.stall;

  // Conditional jumps fall back to PC+2 (select 0) when the compare fails.
  always_comb begin
    w_pc_src = 4'd0;
    if (r_state == c_EXEC) begin
      case (r_op_reg)
        4'h1:    w_pc_src = bus.cmpTrue ? 4'd1 : 4'd0;
        4'h2:    w_pc_src = 4'd2;
        4'h3:    w_pc_src = 4'd3;
        4'h4:    w_pc_src = 4'd4;
        4'h5:    w_pc_src = 4'd5;
        4'h6:    w_pc_src = bus.cmpTrue ? 4'd6 : 4'd0;
        4'h7:    w_pc_src = bus.cmpTrue ? 4'd7 : 4'd0;
        default: w_pc_src = 4'd0;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= c_IDLE;
      r_op_reg      <= 4'd0;
      r_instr_count <= 16'd0;
    end else begin
      r_state <= w_next_state;
      if (w_ir_write) begin
        r_op_reg <= bus.opcode;
      end
      if (w_pc_write) begin
        r_instr_count <= r_instr_count + 16'd1;
      end
    end
  end

  assign bus.pcSrc      = w_pc_src;
  assign bus.pcWrite    = w_pc_write;
  assign bus.irWrite    = w_ir_write;
  assign bus.halted     = (r_state == c_HALT);
  assign bus.instrCount = r_instr_count;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Randomized self-checking bench for pc_sequencer against an
//            instruction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  logic clock = 1'b0;
  logic reset;

  pc_sequencer_if bus ();

  pc_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] m_count;
  logic [22:0] obs;
  logic [22:0] e;

  assign obs = {bus.irWrite, bus.pcWrite, bus.halted, bus.pcSrc, bus.instrCount};

  // Jump-target select an instruction should present while executing
  function automatic logic [3:0] ref_src(input logic [3:0] op, input logic cmp);
    if (op >= 4'h2 && op <= 4'h5) return op;
    if (op == 4'h1 || op == 4'h6 || op == 4'h7) return cmp ? op : 4'h0;
    return 4'h0;
  endfunction

  function automatic logic [22:0] pack(input logic ir, input logic pw, input logic hl,
                                       input logic [3:0] src, input logic [15:0] cnt);
    return {ir, pw, hl, src, cnt};
  endfunction

  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic start_run();
    bus.start    = 1'b1;
    bus.memReady = 1'($urandom);
    #1;
    e = pack(1'b0, 1'b0, 1'b0, 4'd0, m_count);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL idle_start: got %h want %h", obs, e); end
    cyc();
    bus.start = 1'b0;
  endtask

  // One instruction from FETCH entry; for op 0xF returns in HALT unchecked
  task automatic run_instr(input logic [3:0] op, input int waits, input int stalls, input logic cmp);
    for (int i = 0; i < waits; i++) begin
      bus.memReady = 1'b0;
      bus.opcode   = 4'($urandom);
      bus.stall    = 1'($urandom);
      bus.cmpTrue  = 1'($urandom);
      #1;
      e = pack(1'b0, 1'b0, 1'b0, 4'd0, m_count);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL fetch_wait op=%h: got %h want %h", op, obs, e); end
      cyc();
    end
    bus.memReady = 1'b1;
    bus.opcode   = op;
    bus.stall    = 1'b0;
    #1;
    e = pack(1'b1, 1'b0, 1'b0, 4'd0, m_count);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL fetch op=%h: got %h want %h", op, obs, e); end
    cyc();
    bus.memReady = 1'($urandom);
    bus.opcode   = 4'($urandom);
    bus.cmpTrue  = 1'($urandom);
    #1;
    e = pack(1'b0, 1'b0, 1'b0, 4'd0, m_count);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL decode op=%h: got %h want %h", op, obs, e); end
    cyc();
    if (op == 4'hF) return;
    for (int i = 0; i < stalls; i++) begin
      bus.stall    = 1'b1;
      bus.cmpTrue  = 1'($urandom);
      bus.memReady = 1'($urandom);
      #1;
      e = pack(1'b0, 1'b0, 1'b0, ref_src(op, bus.cmpTrue), m_count);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL exec_stall op=%h: got %h want %h", op, obs, e); end
      cyc();
    end
    bus.stall   = 1'b0;
    bus.cmpTrue = cmp;
    #1;
    e = pack(1'b0, 1'b1, 1'b0, ref_src(op, cmp), m_count);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL exec op=%h cmp=%0b: got %h want %h", op, cmp, obs, e); end
    cyc();
    m_count = m_count + 16'd1;
    bus.memReady = 1'b0;
  endtask

  task automatic idle_after_reset(input int n);
    bus.start    = 1'b0;
    bus.memReady = 1'b1;
    for (int i = 0; i < n; i++) begin
      #1;
      e = pack(1'b0, 1'b0, 1'b0, 4'd0, 16'd0);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL idle_wait: got %h want %h", obs, e); end
      cyc();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b1;
    bus.memReady = 1'b1;
    cyc();
    cyc();
    #1;
    e = pack(1'b0, 1'b0, 1'b0, 4'd0, 16'd0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_state: got %h want %h", obs, e); end
    cyc();
    reset = 1'b0;
    m_count = 16'd0;
    idle_after_reset(3);
  endtask

  task automatic test_straight_line();
    start_run();
    bus.memReady = 1'b1;
    bus.opcode   = 4'h0;
    bus.stall    = 1'b0;
    for (int k = 0; k < 12; k++) begin
      bus.cmpTrue = 1'($urandom);
      #1;
      e = pack(k % 3 == 0, k % 3 == 2, 1'b0, 4'd0, 16'(k / 3));
      checks++;
      if (obs !== e) begin errors++; $display("FAIL straight cycle %0d: got %h want %h", k, obs, e); end
      cyc();
    end
    #1;
    e = pack(1'b1, 1'b0, 1'b0, 4'd0, 16'd4);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL straight_count: got %h want %h", obs, e); end
    m_count = 16'd4;
  endtask

  task automatic test_branch();
    logic [3:0] ops  [12];
    logic       cmps [12];
    ops  = '{4'h6, 4'h6, 4'h3, 4'h3, 4'h1, 4'h1, 4'h7, 4'h7, 4'h2, 4'h4, 4'h5, 4'h9};
    cmps = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 12; i++) run_instr(ops[i], 0, 0, cmps[i]);
  endtask

  task automatic test_mem_wait();
    run_instr(4'($urandom_range(0, 14)), 4, 0, 1'($urandom));
  endtask

  task automatic test_stall();
    run_instr(4'h6, 0, 5, 1'b1);
    run_instr(4'h7, 1, 5, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++)
      run_instr(4'($urandom_range(0, 14)), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
  endtask

  task automatic test_halt();
    run_instr(4'hF, $urandom_range(0, 2), 0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      bus.start    = 1'b1;
      bus.memReady = 1'($urandom);
      bus.stall    = 1'($urandom);
      bus.cmpTrue  = 1'($urandom);
      #1;
      e = pack(1'b0, 1'b0, 1'b1, 4'd0, m_count);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL halt_hold %0d: got %h want %h", i, obs, e); end
      cyc();
    end
    bus.start = 1'b0;
    reset = 1'b1;
    #1;
    e = pack(1'b0, 1'b0, 1'b0, 4'd0, 16'd0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL halt_reset_async: got %h want %h", obs, e); end
    cyc();
    reset = 1'b0;
    m_count = 16'd0;
    idle_after_reset(3);
  endtask

  task automatic test_reset_mid_exec();
    start_run();
    run_instr(4'h5, 0, 0, 1'b0);
    bus.memReady = 1'b1;
    bus.opcode   = 4'h2;
    #1;
    cyc();
    bus.memReady = 1'b0;
    cyc();
    bus.stall   = 1'b0;
    bus.cmpTrue = 1'b0;
    #1;
    e = pack(1'b0, 1'b1, 1'b0, 4'd2, m_count);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL pre_reset_exec: got %h want %h", obs, e); end
    reset = 1'b1;
    #1;
    e = pack(1'b0, 1'b0, 1'b0, 4'd0, 16'd0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL exec_reset_async: got %h want %h", obs, e); end
    cyc();
    #1;
    checks++;
    if (obs !== e) begin errors++; $display("FAIL exec_reset_edge: got %h want %h", obs, e); end
    reset = 1'b0;
    m_count = 16'd0;
    idle_after_reset(3);
  endtask

  task automatic test_wrap();
    bus.start = 1'b0;
    force dut.r_instr_count = 16'hFFFF;
    cyc();
    release dut.r_instr_count;
    #1;
    e = pack(1'b0, 1'b0, 1'b0, 4'd0, 16'hFFFF);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL wrap_preload: got %h want %h", obs, e); end
    m_count = 16'hFFFF;
    start_run();
    run_instr(4'h2, 1, 1, 1'b0);
    #1;
    e = pack(1'b0, 1'b0, 1'b0, 4'd0, 16'h0000);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL wrap_result: got %h want %h", obs, e); end
  endtask

  initial begin
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.memReady = 1'b0;
    bus.opcode   = 4'h0;
    bus.cmpTrue  = 1'b0;
    bus.stall    = 1'b0;
    m_count      = 16'd0;
    test_reset();
    test_straight_line();
    test_branch();
    test_mem_wait();
    test_stall();
    test_random();
    test_halt();
    test_reset_mid_exec();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Port clock, input, 1: single system clock; all state updates on its rising edge.
REQ-002 Port reset, input, 1: asynchronous, active-high; forces all state and outputs to their reset values immediately.
REQ-003 Port start, input, 1: leaves IDLE; ignored in every other state.
REQ-004 Port memReady, input, 1: instruction memory has valid data this cycle.
REQ-005 Port opcode, input, 4: instruction opcode; valid only while memReady is high in FETCH.
REQ-006 Port cmpTrue, input, 1: comparison result from the ALU; sampled in EXEC.
REQ-007 Port stall, input, 1: holds the sequencer in EXEC with no PC write.
REQ-008 Port pcSrc, output, 4: PC mux select to pc_block.
REQ-009 Port pcWrite, output, 1: PC load enable to pc_block.
REQ-010 Port irWrite, output, 1: instruction register load enable.
REQ-011 Port halted, output, 1: high in HALT.
REQ-012 Port instrCount, output, 16: count of completed PC writes.

Function
REQ-013 The state machine SHALL have states IDLE, FETCH, DECODE, EXEC and HALT, held in a registered state variable.
REQ-014 IDLE SHALL go to FETCH on the first edge with start=1; all enables low.
REQ-015 FETCH SHALL assert irWrite only while memReady=1, latch opcode into opReg on that edge, and go to DECODE; with memReady=0 it stays in FETCH with irWrite=0.
REQ-016 DECODE SHALL last exactly one cycle with all enables low, then go to HALT if opReg=0xF, otherwise to EXEC.
REQ-017 EXEC with stall=0 SHALL assert pcWrite=1 for exactly one cycle, then go to FETCH.
REQ-018 EXEC with stall=1 SHALL keep pcWrite=0 and stay in EXEC; pcSrc SHALL keep tracking opReg/cmpTrue.
REQ-019 pcSrc SHALL be decoded combinationally from opReg and cmpTrue in EXEC, and SHALL be 0 in all other states.
REQ-020 pcSrc decode: 0x1 gives 1 if cmpTrue else 0; 0x2 gives 2; 0x3 gives 3; 0x4 gives 4; 0x5 gives 5.
REQ-021 pcSrc decode (continued): 0x6 gives 6 if cmpTrue else 0; 0x7 gives 7 if cmpTrue else 0; all other opcodes give 0 (PC+2).
REQ-022 The pcSrc encoding SHALL be: 0 PC+2, 1 immPlusPC, 2 immAddr, 3 ra, 4 mary, 5 pcPlusMary, 6 jcmpImm, 7 jcmpImmLS; values 8-15 are never driven.
REQ-023 Minimum instruction latency SHALL be 3 cycles from FETCH entry to the PC write edge, with memReady=1 and stall=0.
REQ-024 instrCount SHALL increment by 1 on every edge where pcWrite=1 and SHALL wrap from 0xFFFF to 0x0000.
REQ-025 HALT SHALL be absorbing until reset: all enables low, halted=1, instrCount frozen, start ignored.
REQ-026 Simultaneous stall=1 and cmpTrue changes in EXEC SHALL write nothing; only the cmpTrue value at the non-stalled edge decides pcSrc.

Reset
REQ-027 On reset=1 the sequencer SHALL enter IDLE and SHALL set opReg=0, instrCount=0, pcSrc=0, pcWrite=0, irWrite=0 and halted=0, asynchronously.
REQ-028 Reset asserted in any state, including mid-EXEC and HALT, SHALL abort the operation without a PC write on that edge.
REQ-029 After reset release the sequencer SHALL wait in IDLE for start.

Verification
REQ-030 Straight-line run: reset, start, memReady=1, opcode=0x0 repeated -> pcWrite pulses every 3rd cycle with pcSrc=0, and instrCount=4 after 12 cycles.
REQ-031 Branch taken/not: opcode=0x6 with cmpTrue=1 -> pcSrc=6 in EXEC; with cmpTrue=0 -> pcSrc=0; opcode=0x3 -> pcSrc=3 regardless of cmpTrue.
REQ-032 Memory wait: memReady=0 for 4 cycles in FETCH -> irWrite=0 and the state stays FETCH; memReady=1 -> irWrite pulses once and DECODE follows.
REQ-033 Stall: stall=1 for 5 cycles in EXEC -> pcWrite=0 throughout, instrCount unchanged; stall=0 -> a single pcWrite, then FETCH.
REQ-034 Halt and reset: opcode=0xF -> HALT after DECODE, halted=1, start ignored; reset mid-EXEC with stall=0 -> no pcWrite, IDLE, instrCount=0.
REQ-035 Counter wrap: preload instrCount to 0xFFFF via 65535 instructions (or force) -> the next PC write gives 0x0000.
